// File: rtl/brg_sram_pkg.sv
// +-----------------------------------------------------------------------+
// | brg_sram_pkg: shared FSM state and request-struct declaration macro.  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

// Packages cannot carry parameters, so the request struct is declared
// per-instance through this macro using the instance's widths.
`define DECLARE_BRG_SRAM_REQ_S(width_mp, addr_width_mp) \
  typedef struct packed { \
    logic                     w; \
    logic [addr_width_mp-1:0] addr; \
    logic [width_mp-1:0]      data; \
    logic [width_mp-1:0]      mask; \
  } brg_sram_req_s

package brg_sram_pkg;

  typedef enum logic [0:0] {
    eINIT  = 1'b0,
    eREADY = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/bsg_mem_1rw_sync_mask_write_bit_synth.sv
// +-----------------------------------------------------------------------+
// | bsg_mem_1rw_sync_mask_write_bit_synth: 1RW sync array, bit-mask write. |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module bsg_mem_1rw_sync_mask_write_bit_synth #(
  parameter  int width_p       = 46,
  parameter  int els_p         = 1024,
  localparam int addr_width_lp = $clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     v_i,
  input  logic                     w_i,
  input  logic [addr_width_lp-1:0] addr_i,
  input  logic [width_p-1:0]       data_i,
  input  logic [width_p-1:0]       w_mask_i,
  output logic [width_p-1:0]       data_o
);

  logic [width_p-1:0] mem [els_p];

  always_ff @(posedge clk_i) begin
    if (v_i && w_i) begin
      mem[addr_i] <= (mem[addr_i] & ~w_mask_i) | (data_i & w_mask_i);
    end
  end

  // Read data only updates on a read; the wrapper owns the holding behaviour.
  always_ff @(posedge clk_i) begin
    if (v_i && !w_i) begin
      data_o <= mem[addr_i];
    end
  end

endmodule

`default_nettype wire

// File: rtl/brg_sram_1rw_mask_init.sv
// +-----------------------------------------------------------------------+
// | brg_sram_1rw_mask_init: self-initialising masked 1RW SRAM wrapper.    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module brg_sram_1rw_mask_init
  import brg_sram_pkg::*;
#(
  parameter  int                 width_p       = 46,
  parameter  int                 els_p         = 1024,
  parameter  logic [width_p-1:0] init_val_p    = '0,
  localparam int                 addr_width_lp = $clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     v_i,
  input  logic                     w_i,
  input  logic [addr_width_lp-1:0] addr_i,
  input  logic [width_p-1:0]       data_i,
  input  logic [width_p-1:0]       w_mask_i,
  output logic                     ready_o,
  output logic                     init_done_o,
  output logic [width_p-1:0]       data_o,
  output logic                     data_v_o
);

  `DECLARE_BRG_SRAM_REQ_S(width_p, addr_width_lp);

  localparam logic [addr_width_lp-1:0] last_addr_lp = addr_width_lp'(els_p - 1);
  localparam logic [addr_width_lp:0]   els_lp       = (addr_width_lp + 1)'(els_p);

  state_e                   state;
  logic [addr_width_lp-1:0] cnt;
  brg_sram_req_s            user_req;
  brg_sram_req_s            mem_req;
  logic                     mem_v;
  logic                     accept;
  logic                     read_accept;
  logic                     data_v_r;
  logic [width_p-1:0]       hold_r;
  logic [width_p-1:0]       mem_data;

  assign ready_o     = (state == eREADY);
  assign init_done_o = (state == eREADY);
  assign accept      = v_i & ready_o;
  assign read_accept = accept & ~w_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= eINIT;
      cnt   <= '0;
    end else if (state == eINIT) begin
      cnt <= cnt + 1'b1;
      // Explicit terminal compare so non-power-of-two depths stop on time.
      if (cnt == last_addr_lp) begin
        state <= eREADY;
      end
    end
  end

  assign user_req = '{w: w_i, addr: addr_i, data: data_i, mask: w_mask_i};

  always_comb begin
    mem_req = user_req;
    mem_v   = v_i & ~reset_i;
    if (state == eINIT) begin
      mem_v        = ~reset_i;
      mem_req.w    = 1'b1;
      mem_req.addr = cnt;
      mem_req.data = init_val_p;
      mem_req.mask = '1;
    end
  end

  bsg_mem_1rw_sync_mask_write_bit_synth #(
    .width_p (width_p),
    .els_p   (els_p)
  ) mem_array (
    .clk_i    (clk_i),
    .v_i      (mem_v),
    .w_i      (mem_req.w),
    .addr_i   (mem_req.addr),
    .data_i   (mem_req.data),
    .w_mask_i (mem_req.mask),
    .data_o   (mem_data)
  );

  // The array output is trusted only in the cycle after a read; afterwards
  // the captured copy in hold_r drives data_o.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_v_r <= 1'b0;
      hold_r   <= '0;
    end else begin
      data_v_r <= read_accept;
      if (data_v_r) begin
        hold_r <= mem_data;
      end
    end
  end

  assign data_o   = data_v_r ? mem_data : hold_r;
  assign data_v_o = data_v_r;

  a_addr_in_range: assert property (
    @(posedge clk_i) disable iff (reset_i) accept |-> ({1'b0, addr_i} < els_lp)
  );

endmodule

`default_nettype wire

// File: tb/tb_brg_sram_1rw_mask_init.sv
// +-----------------------------------------------------------------------+
// | tb_brg_sram_1rw_mask_init: directed bench, 16-deep and 10-deep DUTs.  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_brg_sram_1rw_mask_init;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [45:0] all_ones = '1;
  localparam logic [45:0] init10   = 46'h15555;

  logic        reset, v, w;
  logic [3:0]  addr;
  logic [45:0] data, mask;
  logic        ready, done, dv;
  logic [45:0] dout;

  logic        reset10, v10, w10;
  logic [3:0]  addr10;
  logic [45:0] data10, mask10;
  logic        ready10, done10, dv10;
  logic [45:0] dout10;

  int vectors = 0;
  int miscompares = 0;

  brg_sram_1rw_mask_init #(.width_p(46), .els_p(16), .init_val_p(46'h0)) dut16 (
    .clk_i(clk), .reset_i(reset), .v_i(v), .w_i(w), .addr_i(addr),
    .data_i(data), .w_mask_i(mask), .ready_o(ready), .init_done_o(done),
    .data_o(dout), .data_v_o(dv)
  );

  brg_sram_1rw_mask_init #(.width_p(46), .els_p(10), .init_val_p(init10)) dut10 (
    .clk_i(clk), .reset_i(reset10), .v_i(v10), .w_i(w10), .addr_i(addr10),
    .data_i(data10), .w_mask_i(mask10), .ready_o(ready10), .init_done_o(done10),
    .data_o(dout10), .data_v_o(dv10)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr16(input logic [3:0] a, input logic [45:0] d, input logic [45:0] m);
    v = 1'b1; w = 1'b1; addr = a; data = d; mask = m;
    step();
    v = 1'b0;
  endtask

  task automatic rd16(input logic [3:0] a);
    v = 1'b1; w = 1'b0; addr = a;
    step();
    v = 1'b0;
  endtask

  task automatic rd10(input logic [3:0] a);
    v10 = 1'b1; w10 = 1'b0; addr10 = a;
    step();
    v10 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    vectors++;
    if ({ready, done, dv} !== 3'b000 || dout !== 46'h0) begin
      miscompares++;
      $display("FAIL reset_state: ready/done/dv=%b%b%b data_o=%h, required 000 and 0",
               ready, done, dv, dout);
    end
  endtask

  task automatic test_init_sweep();
    int n = 0;
    bit dv_seen = 1'b0;
    reset = 1'b0;
    while (!ready && n < 100) begin
      if (dv) dv_seen = 1'b1;
      n++;
      step();
    end
    vectors++;
    if (n != 16 || dv_seen || !done) begin
      miscompares++;
      $display("FAIL init_sweep_len: cycles=%0d dv_seen=%0b done=%0b, required 16/0/1",
               n, dv_seen, done);
    end
    for (int i = 0; i < 16; i++) begin
      rd16(4'(i));
      vectors++;
      if (dout !== 46'h0 || dv !== 1'b1) begin
        miscompares++;
        $display("FAIL init_read[%0d]: data_o=%h dv=%0b, required 0 dv=1", i, dout, dv);
      end
    end
  endtask

  task automatic test_mask_write();
    wr16(4'd5, 46'h3FFF_FFFF_FFFF, 46'h0000_0000_FFFF);
    vectors++;
    if (dv !== 1'b0) begin
      miscompares++;
      $display("FAIL write_no_pulse: dv=%0b, required 0", dv);
    end
    rd16(4'd5);
    vectors++;
    if (dout !== 46'h0000_0000_FFFF || dv !== 1'b1) begin
      miscompares++;
      $display("FAIL mask_read: data_o=%h dv=%0b, required 0000ffff dv=1", dout, dv);
    end
    step();
    vectors++;
    if (dout !== 46'h0000_0000_FFFF || dv !== 1'b0) begin
      miscompares++;
      $display("FAIL mask_hold: data_o=%h dv=%0b, required 0000ffff dv=0", dout, dv);
    end
  endtask

  task automatic test_back_to_back();
    v = 1'b1; w = 1'b1; addr = 4'd7; data = 46'h1234; mask = all_ones;
    step();
    w = 1'b0;
    step();
    vectors++;
    if (dout !== 46'h1234 || dv !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_read: data_o=%h dv=%0b, required 1234 dv=1", dout, dv);
    end
    w = 1'b1; data = 46'h0;
    step();
    v = 1'b0;
    vectors++;
    if (dout !== 46'h1234 || dv !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_hold: data_o=%h dv=%0b, required 1234 dv=0", dout, dv);
    end
    rd16(4'd7);
    vectors++;
    if (dout !== 46'h0 || dv !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_reread: data_o=%h dv=%0b, required 0 dv=1", dout, dv);
    end
  endtask

  task automatic test_reset_read();
    rd16(4'd5);
    v = 1'b1; w = 1'b0; addr = 4'd5; reset = 1'b1;
    step();
    v = 1'b0;
    vectors++;
    if (dv !== 1'b0 || dout !== 46'h0 || ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_wins: dv=%0b data_o=%h ready=%0b, required 0/0/0", dv, dout, ready);
    end
  endtask

  task automatic test_reset_mid_init();
    int n = 0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (8) step();
    vectors++;
    if (ready !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_init_ready: ready=%0b, required 0", ready);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    while (!ready && n < 100) begin
      n++;
      step();
    end
    vectors++;
    if (n != 16) begin
      miscompares++;
      $display("FAIL mid_init_restart: cycles=%0d, required 16", n);
    end
  endtask

  task automatic test_requests_during_init();
    int n = 0;
    bit dv_seen = 1'b0;
    wr16(4'd2, 46'hABC, all_ones);
    reset = 1'b1;
    repeat (2) step();
    v = 1'b1; w = 1'b1; addr = 4'd2; data = 46'hFFFF; mask = all_ones;
    reset = 1'b0;
    while (!ready && n < 100) begin
      if (dv) dv_seen = 1'b1;
      n++;
      step();
    end
    v = 1'b0;
    vectors++;
    if (n != 16 || dv_seen) begin
      miscompares++;
      $display("FAIL init_ignores_v: cycles=%0d dv_seen=%0b, required 16/0", n, dv_seen);
    end
    rd16(4'd2);
    vectors++;
    if (dout !== 46'h0 || dv !== 1'b1) begin
      miscompares++;
      $display("FAIL init_overwrite: data_o=%h dv=%0b, required 0 dv=1", dout, dv);
    end
  endtask

  task automatic test_non_pow2();
    int n = 0;
    reset10 = 1'b1;
    repeat (2) step();
    reset10 = 1'b0;
    while (!ready10 && n < 100) begin
      n++;
      step();
    end
    vectors++;
    if (n != 10 || !done10) begin
      miscompares++;
      $display("FAIL np2_len: cycles=%0d done=%0b, required 10/1", n, done10);
    end
    rd10(4'd9);
    vectors++;
    if (dout10 !== init10 || dv10 !== 1'b1) begin
      miscompares++;
      $display("FAIL np2_read9: data_o=%h dv=%0b, required %h dv=1", dout10, dv10, init10);
    end
    rd10(4'd0);
    vectors++;
    if (dout10 !== init10) begin
      miscompares++;
      $display("FAIL np2_read0: data_o=%h, required %h", dout10, init10);
    end
    v10 = 1'b1; w10 = 1'b1; addr10 = 4'd9; data10 = 46'h0; mask10 = 46'hF0;
    step();
    v10 = 1'b0;
    rd10(4'd9);
    vectors++;
    if (dout10 !== 46'h15505) begin
      miscompares++;
      $display("FAIL np2_mask: data_o=%h, required 15505", dout10);
    end
  endtask

  initial begin
    reset = 1'b1; v = 1'b0; w = 1'b0; addr = '0; data = '0; mask = '0;
    reset10 = 1'b1; v10 = 1'b0; w10 = 1'b0; addr10 = '0; data10 = '0; mask10 = '0;
    @(negedge clk);
    test_reset();
    test_init_sweep();
    test_mask_write();
    test_back_to_back();
    test_reset_read();
    test_reset_mid_init();
    test_requests_during_init();
    test_non_pow2();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/brg_sram_1rw_mask_init.md
# brg_sram_1rw_mask_init

Parametrised single-port synchronous SRAM block for the vanilla-bean core. It generalises the fixed 1024x46 macro shim to arbitrary width and depth, and adds per-bit write masking. It self-initialises every word after reset and holds read data stably between reads. It sits between core-side request logic and the raw storage array, and presents a valid/ready request interface.

## Interface
Parameters:
- `width_p`, 46, data word width in bits.
- `els_p`, 1024, number of words; need not be a power of two.
- `init_val_p`, 0, value (`width_p` bits) written to every word during initialisation.
- `addr_width_lp`, `$clog2(els_p)`, derived address width; not overridable.

Ports:
- `clk_i`  in  1  sole clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `v_i`  in  1  request valid.
- `w_i`  in  1  1 = write, 0 = read; qualified by `v_i`.
- `addr_i`  in  `addr_width_lp`  word address.
- `data_i`  in  `width_p`  write data.
- `w_mask_i`  in  `width_p`  per-bit write enable, active-high; ignored on reads.
- `ready_o`  out  1  block accepts a request this cycle.
- `init_done_o`  out  1  initialisation sweep complete; stays high until the next reset.
- `data_o`  out  `width_p`  read data.
- `data_v_o`  out  1  one-cycle pulse; `data_o` carries new read data this cycle.

## Operation
- FSM states: `eINIT` and `eREADY`.
  - Reset forces `eINIT` and clears the sweep counter to 0.
- `eINIT`:
  - Each cycle, write `init_val_p` (full mask) to address `cnt`, then increment `cnt`.
  - In the cycle that writes `els_p-1`, the next state is `eREADY`.
  - `ready_o`=0 and `init_done_o`=0 throughout.
  - `v_i` is ignored, with no side effects.
- `eREADY`:
  - `ready_o`=1 and `init_done_o`=1.
  - A request is accepted when `v_i & ready_o`.
- Write accepted: for each bit with `w_mask_i[b]`=1, `mem[addr_i][b]` ← `data_i[b]`. Other bits are unchanged. `data_v_o` does not pulse.
- Read accepted: the next cycle, `data_o` = `mem[addr_i]` and `data_v_o`=1.
- `data_o` holds its last read value until the next accepted read. Writes, idle cycles and init do not disturb it. This holding is done by an output register/latch-enable, never by relying on the macro.
- Write to A, then read A the next cycle: the read returns the post-write value. There is no bypass path; the array write completes first.
- Arithmetic: `cnt` is `addr_width_lp` bits. The terminal compare is `cnt == els_p-1`, not counter wrap, so non-power-of-two depths end correctly.
- `addr_i >= els_p` on an accepted request is illegal. A simulation assertion fires, and the RTL result is unspecified.
- Reset mid-init restarts the sweep from address 0.
- Reset mid-operation: a read accepted in the cycle before reset produces no `data_v_o` pulse; reset wins.

## Timing
- Reset values: `ready_o`=0, `init_done_o`=0, `data_v_o`=0, `data_o`=0.
- Init length: exactly `els_p` cycles.
  - With `reset_i` deasserted at edge 0, `ready_o` rises at edge `els_p`.
  - The first request can be accepted in that cycle.
- Read latency: 1 cycle, from the accept edge to `data_o`/`data_v_o` valid.
- Throughput: one request per cycle, reads and writes freely interleaved.
- `ready_o` is a pure function of state. It never depends combinationally on `v_i`.

## Structure
- Shared package `brg_sram_pkg`:
  - state enum `{eINIT, eREADY}`;
  - a request struct `{w, addr, data, mask}` parametrised through the package's width macros.
- Sub-module: `bsg_mem_1rw_sync_mask_write_bit_synth` (`width_p`, `els_p`) as the storage array.
  - The top owns the FSM, sweep counter, request mux (init vs. user), output hold register and `data_v_o` flop.
  - The array port mux selects the sweep address/data/full mask in `eINIT`, and the user request otherwise.

## Test plan
- Init sweep (`els_p`=16, `init_val_p`=`46'h0`): hold `reset_i` for 3 cycles, then release. Required: `ready_o`=0 for exactly 16 cycles then 1, and reads of addresses 0..15 all return 0.
- Mask write: write `data_i`=`46'h3FFF_FFFF_FFFF` to addr 5 with `w_mask_i`=`46'h0000_0000_FFFF`, then read 5. Required: `data_o`=`46'h0000_0000_FFFF`, with `data_v_o` high exactly one cycle.
- Back-to-back: write `46'h1234` to addr 7, next cycle read 7, next cycle write `46'h0` to 7. Required: the read returns `46'h1234`, and `data_o` stays `46'h1234` after the second write.
- Non-power-of-two (`els_p`=10): `ready_o` rises after exactly 10 cycles, and addr 9 reads `init_val_p`.
- Reset mid-init (`els_p`=16): assert `reset_i` at sweep cycle 8. Required: the sweep restarts, and `ready_o` rises exactly 16 cycles after the release.
- Requests during init: drive `v_i`=1, `w_i`=1 with `46'hFFFF` to addr 2 throughout the sweep. Required: addr 2 reads `init_val_p` afterwards, and no `data_v_o` pulse occurs during init.
